// File: rtl/uart_loop_fifo_if.sv
// uart_loop_fifo_if: RX-capture / TX-launch handshake and status bundle
// for uart_loop_fifo. Signal names are from the FIFO's point of view.
interface uart_loop_fifo_if #(
   parameter int ADDR_W = 4
) ();
   logic              i_Rx_DV;
   logic [7:0]        i_Rx_Byte;
   logic              i_Tx_Active;
   logic              i_Tx_Done;
   logic              i_Clear_Ovf;
   logic              o_Tx_DV;
   logic [7:0]        o_Tx_Byte;
   logic [ADDR_W:0]   o_Count;
   logic              o_Empty;
   logic              o_Full;
   logic              o_Overflow;

   // Environment side: UART RX/TX and control logic.
   modport master (
      output i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done, i_Clear_Ovf,
      input  o_Tx_DV, o_Tx_Byte, o_Count, o_Empty, o_Full, o_Overflow
   );

   // FIFO side.
   modport slave (
      input  i_Rx_DV, i_Rx_Byte, i_Tx_Active, i_Tx_Done, i_Clear_Ovf,
      output o_Tx_DV, o_Tx_Byte, o_Count, o_Empty, o_Full, o_Overflow
   );
endinterface

// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo: circular byte FIFO between UART RX and TX in the loopback
// path. Every received byte is queued; a small sequencer launches one byte at
// a time into the transmitter and waits for its done strobe before the next.
module uart_loop_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic            i_Clock,
   input  logic            i_Rst_n,
   uart_loop_fifo_if.slave bus
);

   localparam logic [ADDR_W:0]   C_FULL    = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   C_CNT_ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);

   // Two-bit encoding leaves spare codes; any of them falls back to idle.
   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_DONE = 2'd1
   } state_t;

   logic [7:0]        r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              r_empty;
   logic              r_full;
   logic              r_ovf;
   state_t            r_state;
   logic              r_tx_dv;
   logic [7:0]        r_tx_byte;

   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic [ADDR_W:0]   w_count_nxt;

   // Pop only from idle with data present and the transmitter free; a push is
   // accepted at full when a pop frees a slot in the same cycle.
   always_comb begin
      w_pop       = (r_state == S_IDLE) && !r_empty && !bus.i_Tx_Active;
      w_push      = bus.i_Rx_DV && (!r_full || w_pop);
      w_drop      = bus.i_Rx_DV && r_full && !w_pop;
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - C_CNT_ONE;
      end
   end

   // Byte storage; contents need no reset.
   always_ff @(posedge i_Clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.i_Rx_Byte;
      end
   end

   // Pointers, occupancy and the flags decoded from the next occupancy.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == C_FULL);
      end
   end

   // Sticky overflow: a drop sets it and beats a simultaneous clear.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (bus.i_Clear_Ovf) begin
         r_ovf <= 1'b0;
      end
   end

   // Transmit sequencer: launch one byte, then hold until the TX done strobe.
   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state   <= S_IDLE;
         r_tx_dv   <= 1'b0;
         r_tx_byte <= 8'h00;
      end else begin
         r_tx_dv <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_tx_byte <= r_mem[r_rd_ptr];
                  r_tx_dv   <= 1'b1;
                  r_state   <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (bus.i_Tx_Done) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.o_Tx_DV    = r_tx_dv;
   assign bus.o_Tx_Byte  = r_tx_byte;
   assign bus.o_Count    = r_count;
   assign bus.o_Empty    = r_empty;
   assign bus.o_Full     = r_full;
   assign bus.o_Overflow = r_ovf;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// tb_uart_loop_fifo: directed bench for uart_loop_fifo. A queue-based model
// of the buffer and a simple TX model run alongside the DUT; outputs are
// compared against the model every cycle, and directed tests add literal
// expectations for latency, ordering, full/overflow and reset behaviour.
module tb_uart_loop_fifo;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_loop_fifo_if #(.ADDR_W(ADDR_W)) u_if ();

   uart_loop_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .i_Clock (clk),
      .i_Rst_n (rst_n),
      .bus     (u_if)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   byte unsigned m_q[$];
   bit           m_idle   = 1'b1;
   bit           m_txdv   = 1'b0;
   bit           m_ovf    = 1'b0;
   byte unsigned m_txbyte = 8'h00;

   initial forever begin
      bit pop;
      bit full;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_q.delete();
         m_idle   = 1'b1;
         m_txdv   = 1'b0;
         m_txbyte = 8'h00;
         m_ovf    = 1'b0;
      end else begin
         full   = (m_q.size() == DEPTH);
         pop    = m_idle && (m_q.size() != 0) && !u_if.i_Tx_Active;
         m_txdv = pop;
         if (pop) begin
            m_txbyte = m_q.pop_front();
            m_idle   = 1'b0;
         end else if (!m_idle && u_if.i_Tx_Done) begin
            m_idle = 1'b1;
         end
         if (u_if.i_Rx_DV && (!full || pop)) m_q.push_back(u_if.i_Rx_Byte);
         if (u_if.i_Rx_DV && full && !pop) m_ovf = 1'b1;
         else if (u_if.i_Clear_Ovf)        m_ovf = 1'b0;
      end
   end

   // Every-cycle comparison against the model.
   initial forever begin
      @(negedge clk);
      chk("cyc_tx_dv",   int'(u_if.o_Tx_DV),    int'(m_txdv));
      chk("cyc_tx_byte", int'(u_if.o_Tx_Byte),  int'(m_txbyte));
      chk("cyc_count",   int'(u_if.o_Count),    m_q.size());
      chk("cyc_empty",   int'(u_if.o_Empty),    int'(m_q.size() == 0));
      chk("cyc_full",    int'(u_if.o_Full),     int'(m_q.size() == DEPTH));
      chk("cyc_ovf",     int'(u_if.o_Overflow), int'(m_ovf));
   end

   // ---------------- TX model ----------------
   bit tx_stall   = 1'b0;
   bit tx_release = 1'b0;
   int tx_len     = 5;
   int tx_cnt     = 0;

   initial begin
      u_if.i_Tx_Active = 1'b0;
      u_if.i_Tx_Done   = 1'b0;
      forever begin
         @(negedge clk);
         u_if.i_Tx_Done = 1'b0;
         if (!rst_n) begin
            tx_cnt           = 0;
            u_if.i_Tx_Active = 1'b0;
         end else begin
            if (tx_stall && tx_release && u_if.i_Tx_Active) begin
               u_if.i_Tx_Done   = 1'b1;
               u_if.i_Tx_Active = 1'b0;
               tx_cnt           = 0;
               tx_stall         = 1'b0;
               tx_release       = 1'b0;
            end else if (!tx_stall && tx_cnt > 0) begin
               tx_cnt--;
               if (tx_cnt == 0) begin
                  u_if.i_Tx_Active = 1'b0;
                  u_if.i_Tx_Done   = 1'b1;
               end
            end
            if (u_if.o_Tx_DV) begin
               u_if.i_Tx_Active = 1'b1;
               tx_cnt           = tx_len;
            end
         end
      end
   end

   // ---------------- launch log and protocol ----------------
   byte unsigned tx_log[$];
   int n_launch = 0;
   int n_done   = 0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n)              n_done = 0;
      else if (u_if.i_Tx_Done) n_done++;
   end

   initial forever begin
      @(negedge clk);
      if (!rst_n) n_launch = 0;
      else if (u_if.o_Tx_DV) begin
         chk("launch_after_done", n_done, n_launch);
         n_launch++;
         tx_log.push_back(u_if.o_Tx_Byte);
      end
   end

   // ---------------- helpers ----------------
   task automatic push(input logic [7:0] b);
      u_if.i_Rx_DV   = 1'b1;
      u_if.i_Rx_Byte = b;
      @(negedge clk);
      u_if.i_Rx_DV   = 1'b0;
   endtask

   task automatic wait_log(input int n, input int budget, input string name);
      int k = 0;
      while (tx_log.size() < n && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, tx_log.size(), n);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (!(u_if.o_Empty && !u_if.i_Tx_Active) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("idle_reached", int'(u_if.o_Empty && !u_if.i_Tx_Active), 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_log(input string name, input byte unsigned exp[$]);
      chk({name, "_len"}, tx_log.size(), exp.size());
      for (int i = 0; i < exp.size() && i < tx_log.size(); i++)
         chk($sformatf("%s[%0d]", name, i), int'(tx_log[i]), int'(exp[i]));
   endtask

   // ---------------- directed tests ----------------
   initial begin
      byte unsigned exp_q[$];
      int peak;

      u_if.i_Rx_DV    = 1'b0;
      u_if.i_Rx_Byte  = 8'h00;
      u_if.i_Clear_Ovf = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state.
      chk("rst_tx_dv",   int'(u_if.o_Tx_DV),    0);
      chk("rst_tx_byte", int'(u_if.o_Tx_Byte),  0);
      chk("rst_count",   int'(u_if.o_Count),    0);
      chk("rst_empty",   int'(u_if.o_Empty),    1);
      chk("rst_full",    int'(u_if.o_Full),     0);
      chk("rst_ovf",     int'(u_if.o_Overflow), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);

      // Single byte: count 0,1,0 and launch two cycles after the strobe.
      tx_len = 5;
      tx_log.delete();
      chk("single_count_N", int'(u_if.o_Count), 0);
      u_if.i_Rx_DV   = 1'b1;
      u_if.i_Rx_Byte = 8'hA5;
      @(negedge clk);
      u_if.i_Rx_DV   = 1'b0;
      chk("single_count_N1", int'(u_if.o_Count), 1);
      chk("single_txdv_N1",  int'(u_if.o_Tx_DV), 0);
      @(negedge clk);
      chk("single_txdv_N2",  int'(u_if.o_Tx_DV), 1);
      chk("single_byte_N2",  int'(u_if.o_Tx_Byte), 8'hA5);
      @(negedge clk);
      chk("single_count_N3", int'(u_if.o_Count), 0);
      chk("single_txdv_N3",  int'(u_if.o_Tx_DV), 0);
      wait_idle(100);

      // Burst of five while TX is slow.
      tx_len = 870;
      tx_log.delete();
      peak = 0;
      for (int i = 1; i <= 5; i++) begin
         u_if.i_Rx_DV   = 1'b1;
         u_if.i_Rx_Byte = 8'(i);
         @(negedge clk);
         if (int'(u_if.o_Count) > peak) peak = int'(u_if.o_Count);
      end
      u_if.i_Rx_DV = 1'b0;
      for (int k = 0; k < 6000 && tx_log.size() < 5; k++) begin
         @(negedge clk);
         if (int'(u_if.o_Count) > peak) peak = int'(u_if.o_Count);
      end
      chk("burst_peak", peak, 4);
      exp_q = {};
      for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i));
      chk_log("burst_order", exp_q);
      wait_idle(2000);

      // Fill with TX stalled, then drop one and clear the flag.
      tx_log.delete();
      @(posedge clk);
      tx_stall = 1'b1;
      @(negedge clk);
      for (int i = 8'h10; i <= 8'h20; i++) push(8'(i));
      chk("full_flag",  int'(u_if.o_Full),     1);
      chk("full_count", int'(u_if.o_Count),    DEPTH);
      chk("full_ovf0",  int'(u_if.o_Overflow), 0);
      push(8'h21);
      chk("drop_ovf",   int'(u_if.o_Overflow), 1);
      chk("drop_count", int'(u_if.o_Count),    DEPTH);
      u_if.i_Clear_Ovf = 1'b1;
      @(negedge clk);
      u_if.i_Clear_Ovf = 1'b0;
      chk("clear_ovf",  int'(u_if.o_Overflow), 0);

      // Release TX so a pop lands in the same cycle as a push at full.
      @(posedge clk);
      tx_len     = 3;
      tx_release = 1'b1;
      @(negedge clk);              // done strobe this cycle
      @(negedge clk);              // FSM idle: pop and push together
      push(8'hEE);
      chk("pp_count",   int'(u_if.o_Count),    DEPTH);
      chk("pp_ovf",     int'(u_if.o_Overflow), 0);
      chk("pp_txdv",    int'(u_if.o_Tx_DV),    1);
      chk("pp_txbyte",  int'(u_if.o_Tx_Byte),  8'h11);
      wait_log(18, 400, "pp_drain");
      exp_q = {};
      for (int i = 8'h10; i <= 8'h20; i++) exp_q.push_back(8'(i));
      exp_q.push_back(8'hEE);
      chk_log("full_order", exp_q);
      wait_idle(200);

      // Pointer wrap: 40 bytes through a free-running TX.
      tx_len = 2;
      tx_log.delete();
      for (int i = 0; i < 40; i++) begin
         push(8'(i));
         repeat (2) @(negedge clk);
      end
      wait_log(40, 300, "wrap_drain");
      exp_q = {};
      for (int i = 0; i < 40; i++) exp_q.push_back(8'(i));
      chk_log("wrap_order", exp_q);
      chk("wrap_ovf", int'(u_if.o_Overflow), 0);
      wait_idle(200);

      // Asynchronous reset while waiting for done with three queued.
      tx_len = 870;
      tx_log.delete();
      for (int i = 8'h31; i <= 8'h34; i++) push(8'(i));
      repeat (5) @(negedge clk);
      chk("pre_rst_count", int'(u_if.o_Count), 3);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_count",   int'(u_if.o_Count),   0);
      chk("arst_empty",   int'(u_if.o_Empty),   1);
      chk("arst_tx_dv",   int'(u_if.o_Tx_DV),   0);
      chk("arst_tx_byte", int'(u_if.o_Tx_Byte), 0);
      chk("arst_full",    int'(u_if.o_Full),    0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      tx_log.delete();
      repeat (20) @(negedge clk);
      chk("no_launch_after_rst", tx_log.size(), 0);
      push(8'h77);
      wait_log(1, 20, "post_rst_launch");
      exp_q = {};
      exp_q.push_back(8'h77);
      chk_log("post_rst_order", exp_q);

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
